mem_arbiter: RTL and testbench

//  Sequences the single shared main memory between the I-cache fill port and the D-cache fill/write port.

---
 rtl/mem_arbiter.sv | 178 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Shared main-memory sequencer: arbitrates I-cache line fills against D-cache fills/writes
// and returns the pipelined read words to whichever side currently holds the grant.
module mem_arbiter #(
   parameter int MEM_LAT    = 4,
   parameter int LINE_WORDS = 8
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            i_req,
   input  logic [15:0]                     i_addr,
   input  logic                            d_req,
   input  logic                            d_we,
   input  logic [15:0]                     d_addr,
   input  logic [15:0]                     d_wdata,
   output logic                            i_valid,
   output logic                            d_valid,
   output logic [$clog2(LINE_WORDS)-1:0]   word_idx,
   output logic [15:0]                     rdata,
   output logic                            i_done,
   output logic                            d_done,
   output logic                            mem_en,
   output logic                            mem_wr,
   output logic [15:0]                     mem_addr,
   output logic [15:0]                     mem_wdata,
   input  logic [15:0]                     mem_rdata,
   input  logic                            mem_valid
);
   localparam int IDX_W   = $clog2(LINE_WORDS);
   localparam int OFF_W   = IDX_W + 1;
   localparam int CNT_W   = IDX_W + 1;
   localparam int FLUSH_W = $clog2(MEM_LAT + 1);

   localparam logic [CNT_W-1:0]   LAST_RET   = CNT_W'(LINE_WORDS - 1);
   localparam logic [CNT_W-1:0]   ALL_ISSUED = CNT_W'(LINE_WORDS);
   localparam logic [FLUSH_W-1:0] FLUSH_END  = FLUSH_W'(MEM_LAT - 1);

   typedef enum logic [2:0] {
      FLUSH   = 3'd0,
      IDLE    = 3'd1,
      I_FILL  = 3'd2,
      D_FILL  = 3'd3,
      D_WRITE = 3'd4
   } arbState;

   arbState             stateReg, stateNext;
   logic [FLUSH_W-1:0]  flushCntReg, flushCntNext;
   logic [CNT_W-1:0]    issueCntReg, issueCntNext;
   logic [CNT_W-1:0]    retCntReg, retCntNext;
   logic [15:1]         addrReg, addrNext;
   logic [15:0]         wdataReg, wdataNext;
   logic                lastDReg, lastDNext;

   logic                grantD;
   logic                grantI;
   logic                fillState;
   logic                lastReturn;

   // D wins a tie unless it was the most recent grant, so I waits at most one D op
   assign grantD     = d_req && (!i_req || !lastDReg);
   assign grantI     = i_req && !grantD;
   assign fillState  = (stateReg == I_FILL) || (stateReg == D_FILL);
   assign lastReturn = mem_valid && (retCntReg == LAST_RET);

   // Byte-select bit 0 never reaches memory
   logic unusedAddrBits;
   assign unusedAddrBits = ^{i_addr[0], d_addr[0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         stateReg    <= FLUSH;
         flushCntReg <= '0;
         issueCntReg <= '0;
         retCntReg   <= '0;
         addrReg     <= '0;
         wdataReg    <= '0;
         lastDReg    <= 1'b0;
      end else begin
         stateReg    <= stateNext;
         flushCntReg <= flushCntNext;
         issueCntReg <= issueCntNext;
         retCntReg   <= retCntNext;
         addrReg     <= addrNext;
         wdataReg    <= wdataNext;
         lastDReg    <= lastDNext;
      end
   end

   always_comb begin
      stateNext    = stateReg;
      flushCntNext = flushCntReg;
      issueCntNext = issueCntReg;
      retCntNext   = retCntReg;
      addrNext     = addrReg;
      wdataNext    = wdataReg;
      lastDNext    = lastDReg;
      case (stateReg)
         FLUSH: begin
            // Returns still in flight from before reset land here and are dropped
            if (flushCntReg == FLUSH_END) begin
               stateNext    = IDLE;
               flushCntNext = '0;
            end else begin
               flushCntNext = flushCntReg + 1'b1;
            end
         end
         IDLE: begin
            issueCntNext = '0;
            retCntNext   = '0;
            if (grantD) begin
               stateNext = d_we ? D_WRITE : D_FILL;
               addrNext  = d_addr[15:1];
               wdataNext = d_wdata;
               lastDNext = 1'b1;
            end else if (grantI) begin
               stateNext = I_FILL;
               addrNext  = i_addr[15:1];
               lastDNext = 1'b0;
            end
         end
         I_FILL, D_FILL: begin
            if (issueCntReg != ALL_ISSUED) begin
               issueCntNext = issueCntReg + 1'b1;
            end
            if (mem_valid) begin
               retCntNext = retCntReg + 1'b1;
            end
            if (lastReturn) begin
               stateNext = IDLE;
            end
         end
         D_WRITE: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext = FLUSH;
         end
      endcase
   end

   always_comb begin
      i_valid   = 1'b0;
      d_valid   = 1'b0;
      word_idx  = '0;
      rdata     = '0;
      i_done    = 1'b0;
      d_done    = 1'b0;
      mem_en    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      // Reset gates every output so an aborted op cannot emit anything in its last cycle
      if (!rst) begin
         if (fillState) begin
            if (issueCntReg != ALL_ISSUED) begin
               mem_en   = 1'b1;
               mem_addr = {addrReg[15:OFF_W], issueCntReg[IDX_W-1:0], 1'b0};
            end
            if (mem_valid) begin
               rdata    = mem_rdata;
               word_idx = retCntReg[IDX_W-1:0];
               if (stateReg == I_FILL) begin
                  i_valid = 1'b1;
                  i_done  = lastReturn;
               end else begin
                  d_valid = 1'b1;
                  d_done  = lastReturn;
               end
            end
         end else if (stateReg == D_WRITE) begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = {addrReg, 1'b0};
            mem_wdata = wdataReg;
            d_done    = 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized checks of mem_arbiter against a fixed-latency memory model
// and a spec-level expectation of grant order, addresses, timing and returned data.
module tb_mem_arbiter;
   localparam int MEM_LAT    = 4;
   localparam int LINE_WORDS = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_req;
   logic [15:0] i_addr;
   logic        d_req;
   logic        d_we;
   logic [15:0] d_addr;
   logic [15:0] d_wdata;
   logic        i_valid;
   logic        d_valid;
   logic [2:0]  word_idx;
   logic [15:0] rdata;
   logic        i_done;
   logic        d_done;
   logic        mem_en;
   logic        mem_wr;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic [15:0] mem_rdata;
   logic        mem_valid;

   mem_arbiter #(.MEM_LAT(MEM_LAT), .LINE_WORDS(LINE_WORDS)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .i_valid(i_valid), .d_valid(d_valid), .word_idx(word_idx), .rdata(rdata),
      .i_done(i_done), .d_done(d_done),
      .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_valid(mem_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] initPat(input int k);
      return 16'(k * 40503 + 12345);
   endfunction

   // Memory model: 256 words (byte address bits 8:1), reads return exactly MEM_LAT cycles after issue
   logic        memLoad;
   logic        injValid;
   logic [15:0] memArr [0:255];
   logic [3:0]  pipeV;
   logic [15:0] pipeD [0:3];

   always @(posedge clk) begin
      if (memLoad) begin
         for (int k = 0; k < 256; k++) memArr[k] <= initPat(k);
         pipeV <= '0;
      end else begin
         if (mem_en && mem_wr) memArr[mem_addr[8:1]] <= mem_wdata;
         pipeV <= {pipeV[2:0], mem_en && !mem_wr};
      end
      pipeD[0] <= memArr[mem_addr[8:1]];
      pipeD[1] <= pipeD[0];
      pipeD[2] <= pipeD[1];
      pipeD[3] <= pipeD[2];
   end

   assign mem_valid = pipeV[3] | injValid;
   assign mem_rdata = injValid ? 16'hDEAD : pipeD[3];

   // Reference state: expected memory contents and the fairness history
   logic [15:0] refMem [0:255];
   bit          refLastD;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chkZero(input string tag);
      chk(tag, 64'({i_valid, d_valid, i_done, d_done, mem_en, mem_wr, word_idx}), 64'(0));
      chk(tag, 64'({rdata, mem_addr, mem_wdata}), 64'(0));
   endtask

   // Tie rule: D wins unless D had the most recent grant
   function automatic bit winnerIsD(input bit ri, input bit rd);
      if (rd && ri) return !refLastD;
      return rd;
   endfunction

   task automatic applyReset(input int cycles);
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (cycles) begin
         @(negedge clk);
         chkZero("reset_outputs");
      end
      @(posedge clk); #1;
      rst = 1'b0;
      refLastD = 1'b0;
   endtask

   // Waits for the granted op to start, then checks it cycle by cycle through its done pulse
   task automatic doOp(input bit isD, input bit we, input logic [15:0] addr, input logic [15:0] wdata,
                       input int expStart, input bit holdReq, input bit moveAddr);
      int n;
      int k;
      bit issuing;
      bit returning;
      logic [15:0] base;
      logic [7:0] widx;
      n = 0;
      @(negedge clk);
      while (!mem_en && n < 40) begin
         chk("idle_quiet", 64'({i_valid, d_valid, i_done, d_done}), 64'(0));
         n++;
         @(negedge clk);
      end
      chk("grant_seen", 64'(mem_en), 64'(1));
      if (!mem_en) return;
      chk("start_latency", 64'(n), 64'(expStart));
      $display("op side=%s we=%0d addr=%h start=%0d", isD ? "D" : "I", we, addr, n);
      if (isD && we) begin
         chk("wr_strobes", 64'({mem_en, mem_wr, d_done, d_valid, i_valid, i_done}), 64'(6'b111000));
         chk("wr_addr", 64'(mem_addr), 64'({addr[15:1], 1'b0}));
         chk("wr_data", 64'(mem_wdata), 64'(wdata));
         refMem[addr[8:1]] = wdata;
      end else begin
         base = addr & 16'hFFF0;
         for (int j = 0; j < LINE_WORDS + MEM_LAT; j++) begin
            if (j > 0) @(negedge clk);
            issuing   = (j < LINE_WORDS);
            returning = (j >= MEM_LAT);
            k = j - MEM_LAT;
            chk("fill_issue", 64'({mem_en, mem_wr}), 64'({issuing, 1'b0}));
            if (issuing) chk("fill_addr", 64'(mem_addr), 64'(16'(base + 16'(2 * j))));
            chk("fill_valid", 64'({i_valid, d_valid}),
                64'(returning ? (isD ? 2'b01 : 2'b10) : 2'b00));
            if (returning) begin
               widx = 8'(base[8:1] + 8'(k));
               chk("fill_idx", 64'(word_idx), 64'(k));
               chk("fill_data", 64'(rdata), 64'(refMem[widx]));
            end
            chk("fill_done", 64'({i_done, d_done}),
                64'((j == LINE_WORDS + MEM_LAT - 1) ? (isD ? 2'b01 : 2'b10) : 2'b00));
            if (moveAddr && j == 2) begin
               i_addr = 16'($urandom);
               d_addr = 16'($urandom);
            end
         end
      end
      refLastD = isD;
      @(posedge clk); #1;
      if (!holdReq) begin
         if (isD) d_req = 1'b0;
         else     i_req = 1'b0;
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog timeout");
      $fatal(1, "simulation did not finish");
   end

   initial begin
      bit ri, rd, dWe, first;
      logic [15:0] ia, da, dw;
      int ret, n;
      rst = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
      d_addr = '0; d_wdata = '0; memLoad = 1'b1; injValid = 1'b0; refLastD = 1'b0;
      for (int k = 0; k < 256; k++) refMem[k] = initPat(k);

      applyReset(3);
      memLoad = 1'b0;

      // I fill right after reset: FLUSH(4) + IDLE(1) before the first issue
      i_req = 1'b1; i_addr = 16'h1234;
      doOp(1'b0, 1'b0, 16'h1234, 16'h0, 5, 1'b0, 1'b0);

      // Single-cycle D write, then read its line back
      d_req = 1'b1; d_we = 1'b1; d_addr = 16'h00A3; d_wdata = 16'hBEEF;
      doOp(1'b1, 1'b1, 16'h00A3, 16'hBEEF, 1, 1'b0, 1'b0);
      d_req = 1'b1; d_we = 1'b0; d_addr = 16'h00A8;
      doOp(1'b1, 1'b0, 16'h00A8, 16'h0, 1, 1'b0, 1'b0);

      // Simultaneous requests after reset: D, then I, then D again
      applyReset(2);
      i_req = 1'b1; i_addr = 16'h4560; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h7890;
      doOp(winnerIsD(1'b1, 1'b1), 1'b0, 16'h7890, 16'h0, 5, 1'b0, 1'b0);
      doOp(1'b0, 1'b0, 16'h4560, 16'h0, 1, 1'b0, 1'b0);
      i_req = 1'b1; i_addr = 16'h2222; d_req = 1'b1; d_we = 1'b0; d_addr = 16'h3333;
      doOp(winnerIsD(1'b1, 1'b1), 1'b0, 16'h3333, 16'h0, 1, 1'b0, 1'b0);
      doOp(1'b0, 1'b0, 16'h2222, 16'h0, 1, 1'b0, 1'b0);

      // D held across ops with I pending: D, I, D
      i_req = 1'b1; i_addr = 16'h0F00; d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0044; d_wdata = 16'h1357;
      doOp(winnerIsD(1'b1, 1'b1), 1'b1, 16'h0044, 16'h1357, 1, 1'b1, 1'b0);
      doOp(winnerIsD(1'b1, 1'b1), 1'b0, 16'h0F00, 16'h0, 1, 1'b0, 1'b0);
      doOp(winnerIsD(1'b0, 1'b1), 1'b1, 16'h0044, 16'h1357, 1, 1'b0, 1'b0);

      // Reset after the 3rd return of an I fill
      i_req = 1'b1; i_addr = 16'h5A5A;
      ret = 0; n = 0;
      while (ret < 3 && n < 40) begin
         @(negedge clk);
         if (i_valid) ret++;
         n++;
      end
      chk("abort_progress", 64'(ret), 64'(3));
      @(posedge clk); #1;
      rst = 1'b1;
      @(negedge clk);
      chkZero("abort_reset_cycle");
      @(posedge clk); #1;
      rst = 1'b0;
      refLastD = 1'b0;
      repeat (MEM_LAT) begin
         @(negedge clk);
         chkZero("flush_drain");
      end
      doOp(1'b0, 1'b0, 16'h5A5A, 16'h0, 1, 1'b0, 1'b0);

      // Spurious mem_valid while idle, then address moves mid-fill
      @(posedge clk); #1;
      injValid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("idle_memvalid", 64'({i_valid, d_valid, i_done, d_done, mem_en}), 64'(0));
      end
      @(posedge clk); #1;
      injValid = 1'b0;
      i_req = 1'b1; i_addr = 16'h6B70;
      doOp(1'b0, 1'b0, 16'h6B70, 16'h0, 1, 1'b0, 1'b1);

      // Randomized request mixes
      for (int t = 0; t < 24; t++) begin
         ri = 1'($urandom); rd = 1'($urandom);
         if (!ri && !rd) ri = 1'b1;
         ia = 16'($urandom); da = 16'($urandom); dw = 16'($urandom); dWe = 1'($urandom);
         i_req = ri; i_addr = ia; d_req = rd; d_we = dWe; d_addr = da; d_wdata = dw;
         first = winnerIsD(ri, rd);
         if (first) doOp(1'b1, dWe, da, dw, 1, 1'b0, 1'b0);
         else       doOp(1'b0, 1'b0, ia, 16'h0, 1, 1'b0, 1'b0);
         if (ri && rd) begin
            if (first) doOp(1'b0, 1'b0, ia, 16'h0, 1, 1'b0, 1'b0);
            else       doOp(1'b1, dWe, da, dw, 1, 1'b0, 1'b0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
